cpu_state_dumper: RTL

//  On-chip end-of-run state reader for the single-cycle CPU (sccomp).
//  - Counts retired instructions and stalls the CPU at a programmed stop count or on external halt.
//  - Reads PC, the register file (via reg_sel/reg_data) and data memory.
//  - Streams the snapshot out over a valid/ready word interface to a host or log sink.

---
 rtl/cpu_state_dumper.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: end-of-run state reader for the single-cycle CPU.
// Counts retired instructions, stalls the CPU at STOP_INSTR retires or on
// halt_req, then streams PC, r0..r(NREG-1) and (optionally) dmem words out
// over a valid/ready word port.
//
// Ports:
//   clk, rst (async, active-high)
//   instr_retire, halt_req, pc       : CPU status inputs
//   cpu_stall                        : freezes CPU state writes
//   reg_sel / reg_data               : register-file async read port
//   dm_addr / dm_data                : data-memory async read port
//   out_valid/out_ready/out_data/out_last : snapshot word stream
//   done, instr_count                : status
//
// Build option: define DUMP_DMEM_EN to append dmem[0..DM_WORDS-1] after the
// registers; otherwise the stream ends on r(NREG-1) and dm_addr is tied to 0.

module cpu_state_dumper #(
    parameter int unsigned STOP_INSTR = 200,
    parameter int unsigned NREG       = 32,
    parameter int unsigned DM_WORDS   = 128,
    localparam int unsigned DMW       = $clog2(DM_WORDS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_retire,
    input  logic           halt_req,
    input  logic [31:0]    pc,
    output logic           cpu_stall,
    output logic [4:0]     reg_sel,
    input  logic [31:0]    reg_data,
    output logic [DMW-1:0] dm_addr,
    input  logic [31:0]    dm_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic           out_last,
    output logic           done,
    output logic [31:0]    instr_count
);

`ifdef DUMP_DMEM_EN
    localparam int unsigned NSRC = NREG + DM_WORDS;
`else
    localparam int unsigned NSRC = NREG;
`endif
    // idx walks the word sources after PC; one extra bit so idx+1 never wraps
    localparam int unsigned IW = $clog2(NSRC) + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_SNAP,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [31:0]   r_count;
    logic          r_stall;
    logic [4:0]    r_reg_sel;
    logic [IW-1:0] r_idx;
    logic          r_valid;
    logic [31:0]   r_data;
    logic          r_last;
    logic          r_done;

    logic [31:0]   w_cnt_inc;
    logic [31:0]   w_cnt_next;
    logic          w_hit;
    logic          w_beat;
    logic [IW-1:0] w_idx_nx;
    logic [31:0]   w_src_word;
    logic          w_src_last;

    assign w_cnt_inc  = r_count + 32'd1;
    assign w_cnt_next = instr_retire ? w_cnt_inc : r_count;
    assign w_hit      = (STOP_INSTR != 0) && instr_retire
                        && (w_cnt_inc == 32'(STOP_INSTR));
    assign w_beat     = r_valid & out_ready;
    assign w_idx_nx   = r_idx + IW'(1);
    assign w_src_last = (r_idx == IW'(NSRC - 1));

`ifdef DUMP_DMEM_EN
    logic [DMW-1:0] r_dm_addr;

    // r0 reads as zero whatever the register file returns
    always_comb begin
        w_src_word = dm_data;
        if (r_idx < IW'(NREG))
            w_src_word = (r_idx == '0) ? 32'd0 : reg_data;
    end

    assign dm_addr = r_dm_addr;
`else
    logic w_unused_dm;

    assign w_src_word  = (r_idx == '0) ? 32'd0 : reg_data;
    assign dm_addr     = '0;
    assign w_unused_dm = ^dm_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_count   <= '0;
            r_stall   <= 1'b0;
            r_reg_sel <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DUMP_DMEM_EN
            r_dm_addr <= '0;
`endif
        end else begin
            unique case (r_state)
                S_RUN: begin
                    r_count <= w_cnt_next;
                    if (w_hit || halt_req) begin
                        r_stall <= 1'b1;
                        r_state <= S_SNAP;
                    end
                end
                S_SNAP: begin
                    r_data    <= pc;
                    r_valid   <= 1'b1;
                    r_last    <= 1'b0;
                    r_idx     <= '0;
                    r_reg_sel <= '0;
`ifdef DUMP_DMEM_EN
                    r_dm_addr <= '0;
`endif
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_beat) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_data <= w_src_word;
                            r_last <= w_src_last;
                            r_idx  <= w_idx_nx;
                            // pre-point the read ports at the next source
                            if (w_idx_nx < IW'(NREG))
                                r_reg_sel <= 5'(w_idx_nx);
`ifdef DUMP_DMEM_EN
                            else if (w_idx_nx < IW'(NSRC))
                                r_dm_addr <= DMW'(w_idx_nx - IW'(NREG));
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_stall <= 1'b1;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign cpu_stall   = r_stall;
    assign reg_sel     = r_reg_sel;
    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_last    = r_last;
    assign done        = r_done;
    assign instr_count = r_count;

endmodule
